exc_commit_ctrl: RTL and testbench

Exception/ERTN commit sequencer between the WB stage, the CSR file and pre-IF. It arbitrates the exception sources attached to the WB instruction, including a pending interrupt from the CSR file, by fixed priority. It then drives the one-cycle CSR commit pulses (wb_ex / ertn_flush with ecode, esubcode, pc, vaddr). Finally it flushes the pipeline for a programmable number of cycles and hands the redirect target to pre-IF with a valid/ready handshake.

---
 rtl/exc_commit_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception / ertn commit sequencer.
// Arbitrates WB trap sources, pulses the CSR commit, flushes, then redirects pre-IF.
module exc_commit_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_ex_adef,
    input  logic        wb_ex_ine,
    input  logic        wb_ex_sys,
    input  logic        wb_ex_brk,
    input  logic        wb_ex_ale,
    input  logic        wb_is_ertn,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        wb_allowin,
    output logic        wb_commit_kill,
    output logic        csr_wb_ex,
    output logic        csr_ertn_flush,
    output logic [5:0]  csr_wb_ecode,
    output logic [8:0]  csr_wb_esubcode,
    output logic [31:0] csr_wb_pc,
    output logic [31:0] csr_wb_vaddr,
    output logic        flush_pipe,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_FLUSH,
        S_REDIR
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_dec;
    logic        r_is_ertn;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_pc;
    logic [31:0] r_vaddr;
    logic [31:0] r_target;

    logic        w_any_ex;
    logic        w_trap;
    logic        w_ertn_go;
    logic        w_accept;
    logic [5:0]  w_ecode;
    logic [8:0]  w_esubcode;
    logic [31:0] w_vaddr;

    assign w_any_ex  = wb_ex_adef | wb_ex_ine | wb_ex_sys
                     | wb_ex_brk | wb_ex_ale;
    assign w_trap    = wb_valid & (has_int | w_any_ex);
    assign w_ertn_go = wb_valid & wb_is_ertn & ~w_trap;
    assign w_accept  = (r_state == S_IDLE) & (w_trap | w_ertn_go);
    assign w_cnt_dec = r_cnt - 4'd1;

    // Fixed-priority cause selection; only ADEF and ALE report a bad address.
    always_comb begin
        w_ecode    = 6'h00;
        w_esubcode = 9'd0;
        w_vaddr    = 32'd0;
        priority case (1'b1)
            has_int:    w_ecode = 6'h00;
            wb_ex_adef: begin
                w_ecode = 6'h08;
                w_vaddr = wb_pc;
            end
            wb_ex_ine:  w_ecode = 6'h0D;
            wb_ex_sys:  w_ecode = 6'h0B;
            wb_ex_brk:  w_ecode = 6'h0C;
            wb_ex_ale:  begin
                w_ecode = 6'h09;
                w_vaddr = wb_vaddr;
            end
            default:    w_ecode = 6'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture cause, pc, bad address and redirect target on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_is_ertn  <= 1'b0;
            r_ecode    <= 6'd0;
            r_esubcode <= 9'd0;
            r_pc       <= 32'd0;
            r_vaddr    <= 32'd0;
            r_target   <= 32'd0;
        end else if (w_accept) begin
            r_is_ertn <= w_ertn_go;
            r_pc      <= wb_pc;
            if (w_trap) begin
                r_ecode    <= w_ecode;
                r_esubcode <= w_esubcode;
                r_vaddr    <= w_vaddr;
                r_target   <= ex_entry;
            end else begin
                r_ecode    <= 6'd0;
                r_esubcode <= 9'd0;
                r_vaddr    <= 32'd0;
                r_target   <= ertn_entry;
            end
        end
    end

    // Flush length counter: loaded in COMMIT, counts down through FLUSH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_COMMIT) begin
            r_cnt <= LP_CNT_INIT;
        end else if (r_state == S_FLUSH) begin
            r_cnt <= w_cnt_dec;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt    = r_state;
        wb_allowin     = 1'b0;
        wb_commit_kill = 1'b0;
        csr_wb_ex      = 1'b0;
        csr_ertn_flush = 1'b0;
        flush_pipe     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                wb_allowin     = 1'b1;
                wb_commit_kill = w_trap | w_ertn_go;
                if (w_accept) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                csr_wb_ex      = ~r_is_ertn;
                csr_ertn_flush = r_is_ertn;
                flush_pipe     = 1'b1;
                w_state_nxt    = (FLUSH_CYCLES == 1) ? S_REDIR : S_FLUSH;
            end
            S_FLUSH: begin
                flush_pipe = 1'b1;
                if (w_cnt_dec == 4'd0) begin
                    w_state_nxt = S_REDIR;
                end
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                if (redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign csr_wb_ecode    = r_ecode;
    assign csr_wb_esubcode = r_esubcode;
    assign csr_wb_pc       = r_pc;
    assign csr_wb_vaddr    = r_vaddr;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed bench for exc_commit_ctrl.
// FLUSH_CYCLES = 2: COMMIT at T+1, FLUSH T+2, REDIR T+3.
module tb_exc_commit_ctrl;

    logic        clock;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        wb_ex_adef;
    logic        wb_ex_ine;
    logic        wb_ex_sys;
    logic        wb_ex_brk;
    logic        wb_ex_ale;
    logic        wb_is_ertn;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        wb_allowin;
    logic        wb_commit_kill;
    logic        csr_wb_ex;
    logic        csr_ertn_flush;
    logic [5:0]  csr_wb_ecode;
    logic [8:0]  csr_wb_esubcode;
    logic [31:0] csr_wb_pc;
    logic [31:0] csr_wb_vaddr;
    logic        flush_pipe;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int n_chk;
    int n_err;

    exc_commit_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .wb_valid        (wb_valid),
        .wb_pc           (wb_pc),
        .wb_vaddr        (wb_vaddr),
        .wb_ex_adef      (wb_ex_adef),
        .wb_ex_ine       (wb_ex_ine),
        .wb_ex_sys       (wb_ex_sys),
        .wb_ex_brk       (wb_ex_brk),
        .wb_ex_ale       (wb_ex_ale),
        .wb_is_ertn      (wb_is_ertn),
        .has_int         (has_int),
        .ex_entry        (ex_entry),
        .ertn_entry      (ertn_entry),
        .wb_allowin      (wb_allowin),
        .wb_commit_kill  (wb_commit_kill),
        .csr_wb_ex       (csr_wb_ex),
        .csr_ertn_flush  (csr_ertn_flush),
        .csr_wb_ecode    (csr_wb_ecode),
        .csr_wb_esubcode (csr_wb_esubcode),
        .csr_wb_pc       (csr_wb_pc),
        .csr_wb_vaddr    (csr_wb_vaddr),
        .flush_pipe      (flush_pipe),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_wb();
        wb_valid   = 1'b0;
        wb_ex_adef = 1'b0;
        wb_ex_ine  = 1'b0;
        wb_ex_sys  = 1'b0;
        wb_ex_brk  = 1'b0;
        wb_ex_ale  = 1'b0;
        wb_is_ertn = 1'b0;
        has_int    = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!wb_allowin && k < 20) begin
            step();
            k++;
        end
        chk("drain_idle", 32'(wb_allowin), 32'd1);
    endtask

    initial begin
        n_chk          = 0;
        n_err          = 0;
        reset          = 1'b1;
        wb_pc          = 32'd0;
        wb_vaddr       = 32'd0;
        ex_entry       = 32'd0;
        ertn_entry     = 32'd0;
        redirect_ready = 1'b1;
        clr_wb();
        step();
        step();
        reset = 1'b0;
        #1;

        chk("rst_allowin", 32'(wb_allowin), 32'd1);
        chk("rst_flush", 32'(flush_pipe), 32'd0);
        chk("rst_rvalid", 32'(redirect_valid), 32'd0);
        chk("rst_ecode", 32'(csr_wb_ecode), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);

        // Exception flag without wb_valid does nothing.
        wb_ex_sys = 1'b1;
        #1;
        chk("nv_kill", 32'(wb_commit_kill), 32'd0);
        step();
        chk("nv_idle", 32'(wb_allowin), 32'd1);
        chk("nv_wbex", 32'(csr_wb_ex), 32'd0);
        clr_wb();

        // SYS full timeline.
        wb_valid  = 1'b1;
        wb_ex_sys = 1'b1;
        wb_pc     = 32'h1c000100;
        ex_entry  = 32'h1c008000;
        #1;
        chk("sys_kill_T", 32'(wb_commit_kill), 32'd1);
        step();
        clr_wb();
        #1;
        chk("sys_wbex_T1", 32'(csr_wb_ex), 32'd1);
        chk("sys_ertnf_T1", 32'(csr_ertn_flush), 32'd0);
        chk("sys_ecode", 32'(csr_wb_ecode), 32'h0B);
        chk("sys_esub", 32'(csr_wb_esubcode), 32'd0);
        chk("sys_pc", csr_wb_pc, 32'h1c000100);
        chk("sys_vaddr", csr_wb_vaddr, 32'd0);
        chk("sys_flush_T1", 32'(flush_pipe), 32'd1);
        chk("sys_allow_T1", 32'(wb_allowin), 32'd0);
        step();
        chk("sys_wbex_T2", 32'(csr_wb_ex), 32'd0);
        chk("sys_flush_T2", 32'(flush_pipe), 32'd1);
        chk("sys_rv_T2", 32'(redirect_valid), 32'd0);
        step();
        chk("sys_flush_T3", 32'(flush_pipe), 32'd0);
        chk("sys_rv_T3", 32'(redirect_valid), 32'd1);
        chk("sys_rpc_T3", redirect_pc, 32'h1c008000);
        step();
        chk("sys_rv_T4", 32'(redirect_valid), 32'd0);
        chk("sys_idle_T4", 32'(wb_allowin), 32'd1);
        chk("sys_hold_ecode", 32'(csr_wb_ecode), 32'h0B);

        // Interrupt outranks INE and ALE.
        wb_valid  = 1'b1;
        has_int   = 1'b1;
        wb_ex_ine = 1'b1;
        wb_ex_ale = 1'b1;
        wb_vaddr  = 32'h00000803;
        step();
        clr_wb();
        chk("pri_int", 32'(csr_wb_ecode), 32'h00);
        chk("pri_int_va", csr_wb_vaddr, 32'd0);
        drain();

        // Without the interrupt INE outranks ALE.
        wb_valid  = 1'b1;
        wb_ex_ine = 1'b1;
        wb_ex_ale = 1'b1;
        step();
        clr_wb();
        chk("pri_ine", 32'(csr_wb_ecode), 32'h0D);
        drain();

        // ALE reports the data address.
        wb_valid  = 1'b1;
        wb_ex_ale = 1'b1;
        wb_pc     = 32'h1c000300;
        wb_vaddr  = 32'h00000803;
        step();
        clr_wb();
        chk("ale_ecode", 32'(csr_wb_ecode), 32'h09);
        chk("ale_vaddr", csr_wb_vaddr, 32'h00000803);
        drain();

        // ADEF reports the fetch address.
        wb_valid   = 1'b1;
        wb_ex_adef = 1'b1;
        wb_pc      = 32'h1c000002;
        step();
        clr_wb();
        chk("adef_ecode", 32'(csr_wb_ecode), 32'h08);
        chk("adef_vaddr", csr_wb_vaddr, 32'h1c000002);
        drain();

        // Plain ertn.
        wb_valid   = 1'b1;
        wb_is_ertn = 1'b1;
        wb_pc      = 32'h1c000400;
        ertn_entry = 32'h1c000204;
        ex_entry   = 32'h1c008000;
        #1;
        chk("ertn_kill", 32'(wb_commit_kill), 32'd1);
        step();
        clr_wb();
        chk("ertn_flushpulse", 32'(csr_ertn_flush), 32'd1);
        chk("ertn_wbex", 32'(csr_wb_ex), 32'd0);
        step();
        chk("ertn_pulse_1cyc", 32'(csr_ertn_flush), 32'd0);
        step();
        chk("ertn_rv", 32'(redirect_valid), 32'd1);
        chk("ertn_rpc", redirect_pc, 32'h1c000204);
        drain();

        // ertn with BRK: the exception wins.
        wb_valid   = 1'b1;
        wb_is_ertn = 1'b1;
        wb_ex_brk  = 1'b1;
        step();
        clr_wb();
        chk("ebrk_wbex", 32'(csr_wb_ex), 32'd1);
        chk("ebrk_ertnf", 32'(csr_ertn_flush), 32'd0);
        chk("ebrk_ecode", 32'(csr_wb_ecode), 32'h0C);
        step();
        step();
        chk("ebrk_rpc", redirect_pc, 32'h1c008000);
        drain();

        // Backpressure in REDIR; new SYS must be ignored.
        redirect_ready = 1'b0;
        wb_valid  = 1'b1;
        wb_ex_sys = 1'b1;
        wb_pc     = 32'h1c000500;
        ex_entry  = 32'h1c009000;
        step();
        clr_wb();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            wb_valid  = 1'b1;
            wb_ex_sys = 1'b1;
            wb_pc     = 32'h1c000600 + 32'(i);
            #1;
            chk("bp_rv", 32'(redirect_valid), 32'd1);
            chk("bp_rpc", redirect_pc, 32'h1c009000);
            chk("bp_allow", 32'(wb_allowin), 32'd0);
            chk("bp_kill", 32'(wb_commit_kill), 32'd0);
            step();
        end
        clr_wb();
        redirect_ready = 1'b1;
        #1;
        chk("bp_rv_last", 32'(redirect_valid), 32'd1);
        step();
        chk("bp_idle", 32'(wb_allowin), 32'd1);
        chk("bp_rv_off", 32'(redirect_valid), 32'd0);
        chk("bp_pc_kept", csr_wb_pc, 32'h1c000500);
        step();
        chk("bp_no_retrap", 32'(csr_wb_ex), 32'd0);

        // Reset during FLUSH.
        wb_valid  = 1'b1;
        wb_ex_brk = 1'b1;
        step();
        clr_wb();
        step();
        chk("rf_in_flush", 32'(flush_pipe), 32'd1);
        reset = 1'b1;
        step();
        chk("rf_flush", 32'(flush_pipe), 32'd0);
        chk("rf_rv", 32'(redirect_valid), 32'd0);
        chk("rf_allow", 32'(wb_allowin), 32'd1);
        chk("rf_ecode", 32'(csr_wb_ecode), 32'd0);
        reset = 1'b0;
        step();
        chk("rf_stay_idle", 32'(wb_allowin), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
